// File: rtl/riscv_mc_pkg.sv
// Shared encodings for the multicycle RV32I controller and its decoders.
package riscv_mc_pkg;

    localparam int unsigned OP_W     = 7;
    localparam int unsigned ALUC_W   = 3;
    localparam int unsigned ALUOP_W  = 2;
    localparam int unsigned IMMSRC_W = 2;
    localparam int unsigned SEL_W    = 2;

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECR    = 4'd6,
        EXECI    = 4'd7,
        JAL      = 4'd8,
        ALUWB    = 4'd9,
        BEQ      = 4'd10
    } state_t;

    localparam logic [OP_W-1:0] OP_LOAD  = 7'b0000011;
    localparam logic [OP_W-1:0] OP_STORE = 7'b0100011;
    localparam logic [OP_W-1:0] OP_R     = 7'b0110011;
    localparam logic [OP_W-1:0] OP_I     = 7'b0010011;
    localparam logic [OP_W-1:0] OP_JAL   = 7'b1101111;
    localparam logic [OP_W-1:0] OP_BEQ   = 7'b1100011;

    localparam logic [ALUOP_W-1:0] ALUOP_ADD   = 2'b00;
    localparam logic [ALUOP_W-1:0] ALUOP_SUB   = 2'b01;
    localparam logic [ALUOP_W-1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [ALUC_W-1:0] ALU_ADD = 3'b000;
    localparam logic [ALUC_W-1:0] ALU_SUB = 3'b001;
    localparam logic [ALUC_W-1:0] ALU_AND = 3'b010;
    localparam logic [ALUC_W-1:0] ALU_OR  = 3'b011;
    localparam logic [ALUC_W-1:0] ALU_SLT = 3'b101;

    localparam logic [IMMSRC_W-1:0] IMM_I = 2'b00;
    localparam logic [IMMSRC_W-1:0] IMM_S = 2'b01;
    localparam logic [IMMSRC_W-1:0] IMM_B = 2'b10;
    localparam logic [IMMSRC_W-1:0] IMM_J = 2'b11;

    localparam logic [SEL_W-1:0] SRCA_PC    = 2'b00;
    localparam logic [SEL_W-1:0] SRCA_OLDPC = 2'b01;
    localparam logic [SEL_W-1:0] SRCA_RS1   = 2'b10;

    localparam logic [SEL_W-1:0] SRCB_RS2   = 2'b00;
    localparam logic [SEL_W-1:0] SRCB_IMM   = 2'b01;
    localparam logic [SEL_W-1:0] SRCB_FOUR  = 2'b10;

    localparam logic [SEL_W-1:0] RES_ALUOUT = 2'b00;
    localparam logic [SEL_W-1:0] RES_DATA   = 2'b01;
    localparam logic [SEL_W-1:0] RES_ALURES = 2'b10;

    // Immediate format selected purely by opcode; unknown opcodes fall back to I.
    function automatic logic [IMMSRC_W-1:0] imm_decode(input logic [OP_W-1:0] op);
        case (op)
            OP_LOAD, OP_I: imm_decode = IMM_I;
            OP_STORE:      imm_decode = IMM_S;
            OP_BEQ:        imm_decode = IMM_B;
            OP_JAL:        imm_decode = IMM_J;
            default:       imm_decode = IMM_I;
        endcase
    endfunction

endpackage

// File: rtl/riscv_mc_controller_aludec.sv
// ALU control decode from aluop and instruction function fields.
module riscv_mc_controller_aludec
    import riscv_mc_pkg::*;
(
    input  logic [ALUOP_W-1:0] aluop,
    input  logic [2:0]         funct3,
    input  logic               op5,
    input  logic               funct7b5,
    output logic [ALUC_W-1:0]  alucontrol
);

    // funct3 only matters for ALU-class instructions; sub needs both R-type and funct7b5.
    always_comb begin
        alucontrol = ALU_ADD;
        case (aluop)
            ALUOP_ADD: alucontrol = ALU_ADD;
            ALUOP_SUB: alucontrol = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct3)
                    3'b000:  alucontrol = (op5 & funct7b5) ? ALU_SUB : ALU_ADD;
                    3'b010:  alucontrol = ALU_SLT;
                    3'b110:  alucontrol = ALU_OR;
                    3'b111:  alucontrol = ALU_AND;
                    default: alucontrol = ALU_ADD;
                endcase
            end
            default: alucontrol = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/riscv_mc_controller.sv
// Main control FSM for the multicycle RV32I core with a stallable memory port.
module riscv_mc_controller
    import riscv_mc_pkg::*;
#(
    parameter state_t RESET_STATE = FETCH
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [OP_W-1:0]     op,
    input  logic [2:0]          funct3,
    input  logic                funct7b5,
    input  logic                zero,
    input  logic                mem_ready,
    output logic [IMMSRC_W-1:0] immsrc,
    output logic [ALUC_W-1:0]   alucontrol,
    output logic [SEL_W-1:0]    alusrca,
    output logic [SEL_W-1:0]    alusrcb,
    output logic [SEL_W-1:0]    resultsrc,
    output logic                adrsrc,
    output logic                irwrite,
    output logic                pcwrite,
    output logic                memwrite,
    output logic                regwrite,
    output logic                illegal_instr
);

    state_t               state;
    state_t               state_next;
    logic [ALUOP_W-1:0]   aluop_c;
    logic                 irwrite_c;
    logic                 pcupdate_c;
    logic                 branch_c;
    logic                 memwrite_c;
    logic                 regwrite_c;
    logic                 illegal_c;

    // State register; reset abandons any in-flight instruction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RESET_STATE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and per-state control decode.
    always_comb begin
        state_next = state;
        aluop_c    = ALUOP_ADD;
        alusrca    = SRCA_PC;
        alusrcb    = SRCB_RS2;
        resultsrc  = RES_ALUOUT;
        adrsrc     = 1'b0;
        irwrite_c  = 1'b0;
        pcupdate_c = 1'b0;
        branch_c   = 1'b0;
        memwrite_c = 1'b0;
        regwrite_c = 1'b0;
        illegal_c  = 1'b0;

        case (state)
            FETCH: begin
                alusrca    = SRCA_PC;
                alusrcb    = SRCB_FOUR;
                resultsrc  = RES_ALURES;
                irwrite_c  = mem_ready;
                pcupdate_c = mem_ready;
                if (mem_ready) begin
                    state_next = DECODE;
                end
            end
            DECODE: begin
                alusrca = SRCA_OLDPC;
                alusrcb = SRCB_IMM;
                case (op)
                    OP_LOAD, OP_STORE: state_next = MEMADR;
                    OP_R:              state_next = EXECR;
                    OP_I:              state_next = EXECI;
                    OP_JAL:            state_next = JAL;
                    OP_BEQ:            state_next = BEQ;
                    default: begin
                        state_next = FETCH;
                        illegal_c  = 1'b1;
                    end
                endcase
            end
            MEMADR: begin
                alusrca    = SRCA_RS1;
                alusrcb    = SRCB_IMM;
                state_next = op[5] ? MEMWRITE : MEMREAD;
            end
            MEMREAD: begin
                adrsrc    = 1'b1;
                resultsrc = RES_ALUOUT;
                if (mem_ready) begin
                    state_next = MEMWB;
                end
            end
            MEMWB: begin
                resultsrc  = RES_DATA;
                regwrite_c = 1'b1;
                state_next = FETCH;
            end
            MEMWRITE: begin
                adrsrc     = 1'b1;
                resultsrc  = RES_ALUOUT;
                memwrite_c = 1'b1;
                if (mem_ready) begin
                    state_next = FETCH;
                end
            end
            EXECR: begin
                alusrca    = SRCA_RS1;
                alusrcb    = SRCB_RS2;
                aluop_c    = ALUOP_FUNCT;
                state_next = ALUWB;
            end
            EXECI: begin
                alusrca    = SRCA_RS1;
                alusrcb    = SRCB_IMM;
                aluop_c    = ALUOP_FUNCT;
                state_next = ALUWB;
            end
            JAL: begin
                alusrca    = SRCA_OLDPC;
                alusrcb    = SRCB_FOUR;
                resultsrc  = RES_ALUOUT;
                pcupdate_c = 1'b1;
                state_next = ALUWB;
            end
            ALUWB: begin
                resultsrc  = RES_ALUOUT;
                regwrite_c = 1'b1;
                state_next = FETCH;
            end
            BEQ: begin
                alusrca    = SRCA_RS1;
                alusrcb    = SRCB_RS2;
                aluop_c    = ALUOP_SUB;
                resultsrc  = RES_ALUOUT;
                branch_c   = 1'b1;
                state_next = FETCH;
            end
            default: begin
                state_next = FETCH;
            end
        endcase
    end

    // Enables are forced low while reset is asserted, independent of mem_ready.
    assign irwrite       = rst_n & irwrite_c;
    assign pcwrite       = rst_n & (pcupdate_c | (branch_c & zero));
    assign memwrite      = rst_n & memwrite_c;
    assign regwrite      = rst_n & regwrite_c;
    assign illegal_instr = rst_n & illegal_c;

    // Immediate format follows the instruction register directly.
    assign immsrc = imm_decode(op);

    riscv_mc_controller_aludec u_aludec (
        .aluop      (aluop_c),
        .funct3     (funct3),
        .op5        (op[5]),
        .funct7b5   (funct7b5),
        .alucontrol (alucontrol)
    );

endmodule

// File: tb/tb_riscv_mc_controller.sv
// Directed bench: driver queues expected control vectors, monitor checks each cycle.
module tb_riscv_mc_controller;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       zero;
    logic       mem_ready;
    logic [1:0] immsrc;
    logic [2:0] alucontrol;
    logic [1:0] alusrca;
    logic [1:0] alusrcb;
    logic [1:0] resultsrc;
    logic       adrsrc;
    logic       irwrite;
    logic       pcwrite;
    logic       memwrite;
    logic       regwrite;
    logic       illegal_instr;

    typedef struct packed {
        logic [1:0] imm;
        logic [2:0] aluc;
        logic [1:0] sa;
        logic [1:0] sb;
        logic [1:0] rs;
        logic       adr;
        logic       irw;
        logic       pcw;
        logic       mw;
        logic       rw;
        logic       ill;
    } exp_t;

    typedef struct {
        exp_t  e;
        string name;
    } item_t;

    item_t q[$];
    int    tests = 0;
    int    fails = 0;

    riscv_mc_controller dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .op            (op),
        .funct3        (funct3),
        .funct7b5      (funct7b5),
        .zero          (zero),
        .mem_ready     (mem_ready),
        .immsrc        (immsrc),
        .alucontrol    (alucontrol),
        .alusrca       (alusrca),
        .alusrcb       (alusrcb),
        .resultsrc     (resultsrc),
        .adrsrc        (adrsrc),
        .irwrite       (irwrite),
        .pcwrite       (pcwrite),
        .memwrite      (memwrite),
        .regwrite      (regwrite),
        .illegal_instr (illegal_instr)
    );

    always #5 clk = ~clk;

    function automatic exp_t mk(input logic [1:0] imm, input logic [2:0] aluc,
                                input logic [1:0] sa, input logic [1:0] sb,
                                input logic [1:0] rs, input logic adr, input logic irw,
                                input logic pcw, input logic mw, input logic rw,
                                input logic ill);
        mk = '{imm, aluc, sa, sb, rs, adr, irw, pcw, mw, rw, ill};
    endfunction

    // One clock of stimulus plus the outputs expected while it is applied.
    task automatic cyc(input string nm, input logic mr, input logic z, input exp_t e);
        item_t it;
        mem_ready = mr;
        zero      = z;
        it.e      = e;
        it.name   = nm;
        q.push_back(it);
        @(posedge clk);
        #1;
    endtask

    task automatic set_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7);
        op       = o;
        funct3   = f3;
        funct7b5 = f7;
    endtask

    // Monitor: compare live outputs mid-cycle against the oldest queued expectation.
    always @(negedge clk) begin
        if (q.size() > 0) begin
            item_t it;
            exp_t  act;
            it  = q.pop_front();
            act = '{immsrc, alucontrol, alusrca, alusrcb, resultsrc, adrsrc,
                    irwrite, pcwrite, memwrite, regwrite, illegal_instr};
            tests++;
            if (act !== it.e) begin
                fails++;
                $display("FAIL %s: got %05h expected %05h", it.name, act, it.e);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n     = 1'b0;
        mem_ready = 1'b1;
        zero      = 1'b0;
        set_instr(7'b0000000, 3'b000, 1'b0);
        @(posedge clk);
        #1;

        // Reset held: FETCH selects, every enable low even with mem_ready high.
        cyc("rst_hold0", 1, 0, mk(2'b00, 3'b000, 2'b00, 2'b10, 2'b10, 0, 0, 0, 0, 0, 0));
        cyc("rst_hold1", 1, 0, mk(2'b00, 3'b000, 2'b00, 2'b10, 2'b10, 0, 0, 0, 0, 0, 0));

        // lw with mem_ready low outside memory states (ignored) and one MEMREAD stall.
        set_instr(7'b0000011, 3'b010, 1'b0);
        rst_n = 1'b1;
        cyc("lw_fetch",    1, 0, mk(2'b00, 3'b000, 2'b00, 2'b10, 2'b10, 0, 1, 1, 0, 0, 0));
        cyc("lw_decode",   0, 0, mk(2'b00, 3'b000, 2'b01, 2'b01, 2'b00, 0, 0, 0, 0, 0, 0));
        cyc("lw_memadr",   0, 0, mk(2'b00, 3'b000, 2'b10, 2'b01, 2'b00, 0, 0, 0, 0, 0, 0));
        cyc("lw_memrd_st", 0, 0, mk(2'b00, 3'b000, 2'b00, 2'b00, 2'b00, 1, 0, 0, 0, 0, 0));
        cyc("lw_memrd",    1, 0, mk(2'b00, 3'b000, 2'b00, 2'b00, 2'b00, 1, 0, 0, 0, 0, 0));
        cyc("lw_memwb",    1, 0, mk(2'b00, 3'b000, 2'b00, 2'b00, 2'b01, 0, 0, 0, 0, 1, 0));

        // sw with a FETCH stall and two MEMWRITE stalls.
        set_instr(7'b0100011, 3'b010, 1'b0);
        cyc("sw_fetch_st", 0, 0, mk(2'b01, 3'b000, 2'b00, 2'b10, 2'b10, 0, 0, 0, 0, 0, 0));
        cyc("sw_fetch",    1, 0, mk(2'b01, 3'b000, 2'b00, 2'b10, 2'b10, 0, 1, 1, 0, 0, 0));
        cyc("sw_decode",   1, 0, mk(2'b01, 3'b000, 2'b01, 2'b01, 2'b00, 0, 0, 0, 0, 0, 0));
        cyc("sw_memadr",   1, 0, mk(2'b01, 3'b000, 2'b10, 2'b01, 2'b00, 0, 0, 0, 0, 0, 0));
        cyc("sw_memwr0",   0, 0, mk(2'b01, 3'b000, 2'b00, 2'b00, 2'b00, 1, 0, 0, 1, 0, 0));
        cyc("sw_memwr1",   0, 0, mk(2'b01, 3'b000, 2'b00, 2'b00, 2'b00, 1, 0, 0, 1, 0, 0));
        cyc("sw_memwr2",   1, 0, mk(2'b01, 3'b000, 2'b00, 2'b00, 2'b00, 1, 0, 0, 1, 0, 0));

        // sub: R-type funct3 000 with funct7b5 set.
        set_instr(7'b0110011, 3'b000, 1'b1);
        cyc("sub_fetch",   1, 0, mk(2'b00, 3'b000, 2'b00, 2'b10, 2'b10, 0, 1, 1, 0, 0, 0));
        cyc("sub_decode",  1, 0, mk(2'b00, 3'b000, 2'b01, 2'b01, 2'b00, 0, 0, 0, 0, 0, 0));
        cyc("sub_execr",   1, 0, mk(2'b00, 3'b001, 2'b10, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0));
        cyc("sub_aluwb",   1, 0, mk(2'b00, 3'b000, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 1, 0));

        // add: same fields with funct7b5 clear.
        set_instr(7'b0110011, 3'b000, 1'b0);
        cyc("add_fetch",   1, 0, mk(2'b00, 3'b000, 2'b00, 2'b10, 2'b10, 0, 1, 1, 0, 0, 0));
        cyc("add_decode",  1, 0, mk(2'b00, 3'b000, 2'b01, 2'b01, 2'b00, 0, 0, 0, 0, 0, 0));
        cyc("add_execr",   1, 0, mk(2'b00, 3'b000, 2'b10, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0));
        cyc("add_aluwb",   1, 0, mk(2'b00, 3'b000, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 1, 0));

        // and (R, funct3 111) and slt (R, funct3 010).
        set_instr(7'b0110011, 3'b111, 1'b0);
        cyc("and_fetch",   1, 0, mk(2'b00, 3'b000, 2'b00, 2'b10, 2'b10, 0, 1, 1, 0, 0, 0));
        cyc("and_decode",  1, 0, mk(2'b00, 3'b000, 2'b01, 2'b01, 2'b00, 0, 0, 0, 0, 0, 0));
        cyc("and_execr",   1, 0, mk(2'b00, 3'b010, 2'b10, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0));
        cyc("and_aluwb",   1, 0, mk(2'b00, 3'b000, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 1, 0));
        set_instr(7'b0110011, 3'b010, 1'b0);
        cyc("slt_fetch",   1, 0, mk(2'b00, 3'b000, 2'b00, 2'b10, 2'b10, 0, 1, 1, 0, 0, 0));
        cyc("slt_decode",  1, 0, mk(2'b00, 3'b000, 2'b01, 2'b01, 2'b00, 0, 0, 0, 0, 0, 0));
        cyc("slt_execr",   1, 0, mk(2'b00, 3'b101, 2'b10, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0));
        cyc("slt_aluwb",   1, 0, mk(2'b00, 3'b000, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 1, 0));

        // addi with funct7b5 set must still add (op[5] clear).
        set_instr(7'b0010011, 3'b000, 1'b1);
        cyc("addi_fetch",  1, 0, mk(2'b00, 3'b000, 2'b00, 2'b10, 2'b10, 0, 1, 1, 0, 0, 0));
        cyc("addi_decode", 1, 0, mk(2'b00, 3'b000, 2'b01, 2'b01, 2'b00, 0, 0, 0, 0, 0, 0));
        cyc("addi_execi",  1, 0, mk(2'b00, 3'b000, 2'b10, 2'b01, 2'b00, 0, 0, 0, 0, 0, 0));
        cyc("addi_aluwb",  1, 0, mk(2'b00, 3'b000, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 1, 0));

        // ori (funct3 110) and an unlisted funct3 001 that defaults to add.
        set_instr(7'b0010011, 3'b110, 1'b0);
        cyc("ori_fetch",   1, 0, mk(2'b00, 3'b000, 2'b00, 2'b10, 2'b10, 0, 1, 1, 0, 0, 0));
        cyc("ori_decode",  1, 0, mk(2'b00, 3'b000, 2'b01, 2'b01, 2'b00, 0, 0, 0, 0, 0, 0));
        cyc("ori_execi",   1, 0, mk(2'b00, 3'b011, 2'b10, 2'b01, 2'b00, 0, 0, 0, 0, 0, 0));
        cyc("ori_aluwb",   1, 0, mk(2'b00, 3'b000, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 1, 0));
        set_instr(7'b0010011, 3'b001, 1'b1);
        cyc("f001_fetch",  1, 0, mk(2'b00, 3'b000, 2'b00, 2'b10, 2'b10, 0, 1, 1, 0, 0, 0));
        cyc("f001_decode", 1, 0, mk(2'b00, 3'b000, 2'b01, 2'b01, 2'b00, 0, 0, 0, 0, 0, 0));
        cyc("f001_execi",  1, 0, mk(2'b00, 3'b000, 2'b10, 2'b01, 2'b00, 0, 0, 0, 0, 0, 0));
        cyc("f001_aluwb",  1, 0, mk(2'b00, 3'b000, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 1, 0));

        // beq taken: zero high in DECODE must not write PC; only BEQ does.
        set_instr(7'b1100011, 3'b000, 1'b0);
        cyc("beqt_fetch",  1, 1, mk(2'b10, 3'b000, 2'b00, 2'b10, 2'b10, 0, 1, 1, 0, 0, 0));
        cyc("beqt_decode", 1, 1, mk(2'b10, 3'b000, 2'b01, 2'b01, 2'b00, 0, 0, 0, 0, 0, 0));
        cyc("beqt_beq",    1, 1, mk(2'b10, 3'b001, 2'b10, 2'b00, 2'b00, 0, 0, 1, 0, 0, 0));
        // beq not taken.
        cyc("beqn_fetch",  1, 0, mk(2'b10, 3'b000, 2'b00, 2'b10, 2'b10, 0, 1, 1, 0, 0, 0));
        cyc("beqn_decode", 1, 0, mk(2'b10, 3'b000, 2'b01, 2'b01, 2'b00, 0, 0, 0, 0, 0, 0));
        cyc("beqn_beq",    1, 0, mk(2'b10, 3'b001, 2'b10, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0));

        // jal: PC written in JAL, link register written in ALUWB.
        set_instr(7'b1101111, 3'b000, 1'b0);
        cyc("jal_fetch",   1, 0, mk(2'b11, 3'b000, 2'b00, 2'b10, 2'b10, 0, 1, 1, 0, 0, 0));
        cyc("jal_decode",  1, 0, mk(2'b11, 3'b000, 2'b01, 2'b01, 2'b00, 0, 0, 0, 0, 0, 0));
        cyc("jal_jal",     1, 0, mk(2'b11, 3'b000, 2'b01, 2'b10, 2'b00, 0, 0, 1, 0, 0, 0));
        cyc("jal_aluwb",   1, 0, mk(2'b11, 3'b000, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 1, 0));

        // Illegal opcode: one-cycle flag in DECODE, then straight back to FETCH.
        set_instr(7'b1111111, 3'b000, 1'b0);
        cyc("ill_fetch",   1, 0, mk(2'b00, 3'b000, 2'b00, 2'b10, 2'b10, 0, 1, 1, 0, 0, 0));
        cyc("ill_decode",  1, 0, mk(2'b00, 3'b000, 2'b01, 2'b01, 2'b00, 0, 0, 0, 0, 0, 1));

        // lw interrupted by reset in MEMREAD: no MEMWB afterwards.
        set_instr(7'b0000011, 3'b010, 1'b0);
        cyc("rlw_fetch",   1, 0, mk(2'b00, 3'b000, 2'b00, 2'b10, 2'b10, 0, 1, 1, 0, 0, 0));
        cyc("rlw_decode",  1, 0, mk(2'b00, 3'b000, 2'b01, 2'b01, 2'b00, 0, 0, 0, 0, 0, 0));
        cyc("rlw_memadr",  1, 0, mk(2'b00, 3'b000, 2'b10, 2'b01, 2'b00, 0, 0, 0, 0, 0, 0));
        rst_n = 1'b0;
        cyc("rlw_rst",     1, 0, mk(2'b00, 3'b000, 2'b00, 2'b10, 2'b10, 0, 0, 0, 0, 0, 0));
        rst_n = 1'b1;
        set_instr(7'b0110011, 3'b000, 1'b1);
        cyc("post_fetch",  1, 0, mk(2'b00, 3'b000, 2'b00, 2'b10, 2'b10, 0, 1, 1, 0, 0, 0));
        cyc("post_decode", 1, 0, mk(2'b00, 3'b000, 2'b01, 2'b01, 2'b00, 0, 0, 0, 0, 0, 0));
        cyc("post_execr",  1, 0, mk(2'b00, 3'b001, 2'b10, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0));
        cyc("post_aluwb",  1, 0, mk(2'b00, 3'b000, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 1, 0));
        cyc("end_fetch",   1, 0, mk(2'b00, 3'b000, 2'b00, 2'b10, 2'b10, 0, 1, 1, 0, 0, 0));

        // Let the monitor drain, bounded.
        for (int i = 0; i < 10 && q.size() > 0; i++) begin
            @(posedge clk);
        end
        if (q.size() > 0) begin
            tests++;
            fails++;
            $display("FAIL drain: %0d expectations left unchecked, required 0", q.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/riscv_mc_controller.md
Name: riscv_mc_controller

Overview:
- Main control FSM for the multicycle RV32I core (lw, sw, R-type, I-type ALU, beq, jal).
- Sequences one shared ALU, the instruction/data memory port and the register file over 3–5 cycles per instruction.
- Drives immsrc for the immediate extender, alucontrol for the ALU, and all mux selects and write enables.
- Adds a mem_ready handshake so memory accesses may stall.

Parameters:
- RESET_STATE, FETCH, state entered on reset.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- op  in  7  instr[6:0] from the instruction register
- funct3  in  3  instr[14:12]
- funct7b5  in  1  instr[30]
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory access completes this cycle
- immsrc  out  2  00 I, 01 S, 10 B, 11 J
- alucontrol  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt
- alusrca  out  2  00 PC, 01 OldPC, 10 rs1
- alusrcb  out  2  00 rs2, 01 imm, 10 const 4
- resultsrc  out  2  00 ALUOut, 01 Data, 10 ALUResult
- adrsrc  out  1  0 PC, 1 Result
- irwrite, pcwrite, memwrite, regwrite  out  1 each  write enables
- illegal_instr  out  1  one-cycle pulse on an undecodable opcode

Behaviour:
- Reset:
  - rst_n low sets state to FETCH asynchronously.
  - While rst_n is low, all write enables and illegal_instr are 0. Selects take their FETCH values.
- Output style:
  - All outputs are Moore outputs of state.
  - Exceptions: immsrc decodes from op combinationally; pcwrite = pcupdate | (branch & zero).
- States and per-state outputs (unlisted enables 0, unlisted selects don't-care but driven to 0):
  - FETCH: adrsrc=0, alusrca=00, alusrcb=10, aluop=00, resultsrc=10. irwrite=pcupdate=mem_ready. Stay until mem_ready, then go to DECODE.
  - DECODE: alusrca=01, alusrcb=01, aluop=00. Next state by op:
    - 0000011 or 0100011 -> MEMADR
    - 0110011 -> EXECR
    - 0010011 -> EXECI
    - 1101111 -> JAL
    - 1100011 -> BEQ
    - any other -> FETCH, with illegal_instr=1 for this cycle
  - MEMADR: alusrca=10, alusrcb=01, aluop=00. Next: op[5]=0 -> MEMREAD, else MEMWRITE.
  - MEMREAD: adrsrc=1, resultsrc=00. Hold until mem_ready, then MEMWB.
  - MEMWB: resultsrc=01, regwrite=1, then FETCH.
  - MEMWRITE: adrsrc=1, resultsrc=00, memwrite=1 (held while stalled). Hold until mem_ready, then FETCH.
  - EXECR: alusrca=10, alusrcb=00, aluop=10, then ALUWB.
  - EXECI: alusrca=10, alusrcb=01, aluop=10, then ALUWB.
  - JAL: alusrca=01, alusrcb=10, aluop=00, resultsrc=00, pcupdate=1, then ALUWB.
  - ALUWB: resultsrc=00, regwrite=1, then FETCH.
  - BEQ: alusrca=10, alusrcb=00, aluop=01, resultsrc=00, branch=1, then FETCH.
- ALU decode:
  - aluop 00 -> add. aluop 01 -> sub.
  - aluop 10 by funct3:
    - 000: sub if (op[5] & funct7b5), else add
    - 010: slt
    - 110: or
    - 111: and
    - other: add
- immsrc decode:
  - 0000011 / 0010011 -> 00
  - 0100011 -> 01
  - 1100011 -> 10
  - 1101111 -> 11
  - other -> 00
- Latency (no stalls):
  - lw 5 cycles; sw, R-type, I-type, jal 4 cycles; beq 3 cycles.
  - Each stalled cycle (mem_ready=0 in FETCH, MEMREAD or MEMWRITE) adds 1.
- Boundary conditions:
  - Reset mid-instruction abandons the instruction; the next state is FETCH, with no partial write after release.
  - mem_ready is ignored in every state except FETCH, MEMREAD and MEMWRITE.
  - An undefined state encoding recovers to FETCH.

Decomposition:
- Package riscv_mc_pkg holds:
  - state_t enum
  - opcode constants (OP_LOAD, OP_STORE, OP_R, OP_I, OP_JAL, OP_BEQ)
  - aluop and alucontrol encodings
  - immsrc encodings (shared with the single-cycle decoders)
- Sub-module aludec (aluop, funct3, op5, funct7b5 -> alucontrol) is combinational.
- The FSM plus output/immsrc decode stays in the top level.

Test Plan:
- Hold rst_n=0, then release with mem_ready=1. Required: state FETCH; irwrite=pcwrite=1 on the first clock after release; regwrite=memwrite=0 throughout reset.
- lw (op 0000011), mem_ready=1. Required: states FETCH, DECODE, MEMADR, MEMREAD, MEMWB; immsrc=00; regwrite=1 only in cycle 5 with resultsrc=01.
- sw (op 0100011), mem_ready low for 2 cycles in MEMWRITE. Required: immsrc=01; memwrite=1 for 3 consecutive cycles; then FETCH.
- sub (op 0110011, funct3 000, funct7b5=1). Required: alucontrol=001 in EXECR. Same with funct7b5=0 gives 000. I-type addi with funct7b5=1 gives 000.
- beq (op 1100011), immsrc=10. Required: zero=1 gives pcwrite=1 in BEQ; zero=0 gives pcwrite=0; both return to FETCH after 3 cycles.
- Illegal op 1111111 at DECODE. Required: illegal_instr=1 for exactly 1 cycle; next state FETCH; no write enable asserted.
